// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory stage: access sizes and clear-sequencer states.
package mem_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;
endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half/word out of a little-endian 32-bit word and
// right-justifies it with sign or zero extension.
module load_extend
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        LoadUnsigned,
   output logic [31:0] result
);
   logic [31:0] shifted;
   logic [7:0]  b;
   logic [15:0] h;

   assign shifted = word >> {lane, 3'b000};
   assign b       = shifted[7:0];
   assign h       = lane[1] ? word[31:16] : word[15:0];

   always_comb begin
      result = '0;
      case (size)
         SZ_BYTE: result = {{24{b[7] & ~LoadUnsigned}}, b};
         SZ_HALF: result = {{16{h[15] & ~LoadUnsigned}}, h};
         SZ_WORD: result = word;
         default: result = '0;
      endcase
   end
endmodule

// File: rtl/data_memory.sv
// Byte-addressed data memory behind the ALU with sub-word loads/stores,
// misalignment detection and a post-reset clear sequencer.
module data_memory
   import mem_pkg::*;
#(
   parameter  int DEPTH_WORDS = 256,
   localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [31:0] addr,
   input  logic [31:0] WriteData,
   input  logic [1:0]  size,
   input  logic        LoadUnsigned,
   output logic [31:0] ReadData,
   output logic        Misaligned,
   output logic        Busy
);
   logic [31:0] mem [DEPTH_WORDS];

   state_t           state, state_nxt;
   logic [IDX_W-1:0] clr_idx, clr_idx_nxt;
   logic             busy;
   logic             bad_align;
   logic             do_store;
   logic [IDX_W-1:0] widx;
   logic [31:0]      rword, ext, wdata;
   logic [3:0]       be;
   logic             unused_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_CLEAR;
         clr_idx <= '0;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
      end
   end

   // Counter wraps to 0 on the last word, so IDLE always leaves it at 0.
   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      if (state == ST_CLEAR) begin
         clr_idx_nxt = clr_idx + 1'b1;
         if (&clr_idx) state_nxt = ST_IDLE;
      end
   end

   assign busy = (state == ST_CLEAR);
   assign Busy = busy;

   always_comb begin
      bad_align = 1'b0;
      case (size)
         SZ_BYTE: bad_align = 1'b0;
         SZ_HALF: bad_align = addr[0];
         SZ_WORD: bad_align = |addr[1:0];
         default: bad_align = 1'b1;
      endcase
   end

   assign Misaligned  = ~busy & (MemRead | MemWrite) & bad_align;
   assign widx        = addr[IDX_W+1:2];
   assign unused_addr = ^addr[31:IDX_W+2];
   assign rword       = mem[widx];

   load_extend u_ext (
      .word        (rword),
      .lane        (addr[1:0]),
      .size        (size),
      .LoadUnsigned(LoadUnsigned),
      .result      (ext)
   );

   // Read path sees pre-write contents; a same-cycle store lands at the edge.
   assign ReadData = (~busy & MemRead & ~bad_align) ? ext : '0;

   always_comb begin
      be    = 4'b0000;
      wdata = WriteData;
      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << addr[1:0];
            wdata = {4{WriteData[7:0]}};
         end
         SZ_HALF: begin
            be    = addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{WriteData[15:0]}};
         end
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   assign do_store = ~busy & MemWrite & ~bad_align;

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (busy) begin
            mem[clr_idx] <= '0;
         end else if (do_store) begin
            for (int i = 0; i < 4; i++)
               if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end
endmodule

// File: tb/tb_data_memory.sv
// Randomized and directed checks of data_memory against a byte-array model.
module tb_data_memory;
   localparam int DEPTH  = 256;
   localparam int NBYTES = DEPTH * 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1, MemWrite = 1'b0, MemRead = 1'b0, LoadUnsigned = 1'b0;
   logic [31:0] addr = '0, WriteData = '0;
   logic [1:0]  size = 2'b10;
   logic [31:0] ReadData;
   logic        Misaligned, Busy;

   always #5 clk = ~clk;

   data_memory #(.DEPTH_WORDS(DEPTH)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
      .addr(addr), .WriteData(WriteData), .size(size), .LoadUnsigned(LoadUnsigned),
      .ReadData(ReadData), .Misaligned(Misaligned), .Busy(Busy)
   );

   int n_cmp = 0, n_err = 0;

   // Model: memory as bytes, plus the number of clear cycles still owed.
   logic [7:0] mb [NBYTES];
   int         rem = 0;
   bit         known = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int byte_addr();
      return int'(addr % 32'(NBYTES));
   endfunction

   function automatic logic exp_mis();
      int a;
      a = byte_addr();
      if (rem > 0 || !(MemRead || MemWrite)) return 1'b0;
      case (size)
         2'd1:    return (a % 2) != 0;
         2'd2:    return (a % 4) != 0;
         2'd3:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] exp_rd();
      int a, v;
      a = byte_addr();
      if (rem > 0 || !MemRead || exp_mis()) return 32'h0;
      case (size)
         2'd0: begin
            v = int'(mb[a]);
            if (!LoadUnsigned && v >= 128) v -= 256;
            return 32'(v);
         end
         2'd1: begin
            v = int'(mb[a]) + 256 * int'(mb[a+1]);
            if (!LoadUnsigned && v >= 32768) v -= 65536;
            return 32'(v);
         end
         default: return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         rem   <= DEPTH;
         known <= 1'b1;
      end else if (rem > 0) begin
         for (int k = 0; k < 4; k++) mb[(DEPTH - rem) * 4 + k] <= 8'h00;
         rem <= rem - 1;
      end else if (MemWrite && !exp_mis()) begin
         for (int k = 0; k < (size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4); k++)
            mb[byte_addr() + k] <= WriteData[8*k +: 8];
      end
   end

   always @(negedge clk) begin
      if (known) begin
         chk("busy", 32'(Busy), 32'(rem > 0));
         chk("readdata", ReadData, exp_rd());
         chk("misaligned", 32'(Misaligned), 32'(exp_mis()));
      end
   end

   logic [31:0] obs_rd;
   logic        obs_mis, obs_busy;

   task automatic access(input logic rst, input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic lu);
      reset = rst; MemWrite = we; MemRead = re; addr = a; WriteData = wd; size = sz; LoadUnsigned = lu;
      @(negedge clk);
      obs_rd = ReadData; obs_mis = Misaligned; obs_busy = Busy;
      @(posedge clk);
      #1;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      for (int i = 0; i < 2000; i++) begin
         access(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
         if (!obs_busy) return;
         n++;
      end
      n_cmp++;
      n_err++;
      $display("FAIL busy_timeout: Busy still high after %0d cycles, expected low after %0d", n, DEPTH);
   endtask

   initial begin
      int n;
      int r;
      logic [1:0] sz;

      // reset, then the clear window
      access(1'b1, 0, 0, 0, 0, 2'b10, 0);
      access(1'b1, 0, 0, 0, 0, 2'b10, 0);
      count_busy(n);
      chk("busy_len_initial", 32'(n), 32'd256);
      access(0, 0, 1, 32'h0, 0, 2'b10, 0);       chk("rd_0x0_cleared", obs_rd, 32'h0);
      access(0, 0, 1, 32'h3FC, 0, 2'b10, 0);     chk("rd_0x3fc_cleared", obs_rd, 32'h0);

      // word store/load and wrap
      access(0, 1, 0, 32'h10, 32'hDEADBEEF, 2'b10, 0);
      access(0, 0, 1, 32'h10, 0, 2'b10, 0);      chk("word_ld", obs_rd, 32'hDEADBEEF);
      access(0, 0, 1, 32'h410, 0, 2'b10, 0);     chk("word_ld_wrap", obs_rd, 32'hDEADBEEF);

      // extension
      access(0, 0, 1, 32'h13, 0, 2'b00, 0);      chk("byte_signed", obs_rd, 32'hFFFFFFDE);
      access(0, 0, 1, 32'h13, 0, 2'b00, 1);      chk("byte_unsigned", obs_rd, 32'h000000DE);
      access(0, 0, 1, 32'h10, 0, 2'b01, 0);      chk("half_signed", obs_rd, 32'hFFFFBEEF);
      access(0, 0, 1, 32'h12, 0, 2'b01, 1);      chk("half_hi_unsigned", obs_rd, 32'h0000DEAD);
      access(0, 1, 0, 32'h11, 32'h00000055, 2'b00, 0);
      access(0, 0, 1, 32'h10, 0, 2'b10, 0);      chk("byte_store_merge", obs_rd, 32'hDEAD55EF);

      // misalignment
      access(0, 1, 1, 32'h21, 32'h1234, 2'b01, 0);
      chk("half_mis_flag", 32'(obs_mis), 32'd1);
      chk("half_mis_rd", obs_rd, 32'h0);
      access(0, 0, 1, 32'h20, 0, 2'b10, 0);      chk("mis_no_write", obs_rd, 32'h0);
      access(0, 0, 1, 32'h22, 0, 2'b10, 0);      chk("word_mis", 32'(obs_mis), 32'd1);
      access(0, 0, 1, 32'h20, 0, 2'b11, 0);      chk("size11_mis", 32'(obs_mis), 32'd1);
      access(0, 0, 0, 32'h21, 0, 2'b01, 0);      chk("no_access_mis", 32'(obs_mis), 32'd0);

      // same-cycle read and write: old value visible
      access(0, 1, 1, 32'h10, 32'h11112222, 2'b10, 0); chk("rw_pre_value", obs_rd, 32'hDEAD55EF);
      access(0, 0, 1, 32'h10, 0, 2'b10, 0);            chk("rw_post_value", obs_rd, 32'h11112222);

      // reset mid-use, accesses during clear, reset mid-clear
      access(0, 1, 0, 32'h8, 32'hCAFEF00D, 2'b10, 0);
      access(0, 0, 1, 32'h8, 0, 2'b10, 0);       chk("cafe_written", obs_rd, 32'hCAFEF00D);
      access(1, 0, 0, 32'h0, 0, 2'b10, 0);       chk("busy_before_edge", 32'(obs_busy), 32'd0);
      for (int i = 0; i < 100; i++) begin
         access(0, 1, 1, 32'h0, 32'hFFFFFFFF, 2'b10, 0);
         if (i == 0) chk("busy_rises", 32'(obs_busy), 32'd1);
         if (i == 0 || i == 99) chk("rd_zero_while_busy", obs_rd, 32'h0);
      end
      access(1, 0, 0, 32'h0, 0, 2'b10, 0);
      count_busy(n);
      chk("busy_len_restart", 32'(n), 32'd256);
      access(0, 0, 1, 32'h8, 0, 2'b10, 0);       chk("cafe_cleared", obs_rd, 32'h0);
      access(0, 0, 1, 32'h0, 0, 2'b10, 0);       chk("busy_store_ignored", obs_rd, 32'h0);

      // random traffic on a small window with aliased upper address bits
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 9));
         sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         access($urandom_range(0, 599) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63)), $urandom, sz,
                1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
